// File: rtl/line_ram_responder_pkg.sv
// Shared definitions for the line RAM responder: state encoding, line geometry
// and the packing of the 16-bit state_value debug word (also decoded by the
// DDR3 controller debug display, so the layout must stay in step with it).
package line_ram_responder_pkg;

    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_XFER    = 4'd1,
        ST_DRAIN   = 4'd2,
        ST_ACK     = 4'd3,
        ST_RELEASE = 4'd4,
        ST_WAIT    = 4'd5
    } state_e;

    localparam int unsigned BEATS_PER_LINE   = 8;
    localparam int unsigned WORD_W           = 32;
    localparam int unsigned LINE_W           = 256;
    localparam int unsigned LINE_OFFSET_BITS = 5;
    localparam int unsigned BEAT_W           = $clog2(BEATS_PER_LINE);
    localparam int unsigned REQ_ADDR_W       = 29;

    // state_value = {state[3:0], beat[3:0], op_is_write, 6'b0, busy}
    function automatic logic [15:0] pack_state_value(input state_e st,
                                                     input logic [3:0] beat,
                                                     input logic op_is_write,
                                                     input logic busy);
        return {st, beat, op_is_write, 6'b000000, busy};
    endfunction

    // Word k of a line lives in bits [32k+31:32k].
    function automatic logic [WORD_W-1:0] line_word(input logic [LINE_W-1:0] line,
                                                    input logic [BEAT_W-1:0] k);
        return line[k*WORD_W +: WORD_W];
    endfunction

endpackage

// File: rtl/line_ram_word_mem.sv
// Single-port word RAM behind the line responder. Registered read, and a read
// of the address being written returns the old contents. Kept as its own
// module so a vendor block RAM primitive can be dropped in.
module line_ram_word_mem
    import line_ram_responder_pkg::*;
#(
    parameter int unsigned ADDR_W = 13,
    parameter int unsigned DATA_W = WORD_W
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

    // Synchronous write and read-old registered read; contents have no reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/line_ram_responder.sv
// Responder for the 256-bit cache line interface, backed by on-chip RAM
// organised as eight 32-bit beats per line. Stands in for the DDR3
// controller with the same request/ack handshake.
// Optional macro LINE_RAM_DELAY_EN inserts a WAIT state of DELAY_CYCLES
// cycles before the beat phase to mimic memory latency.
module line_ram_responder
    import line_ram_responder_pkg::*;
#(
    parameter int unsigned LINE_ADDR_W  = 10,
    parameter int unsigned DELAY_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REQ_ADDR_W-1:0] addr_i,
    input  logic [LINE_W-1:0]     data_i,
    output logic [LINE_W-1:0]     data_o,
    input  logic                  we_i,
    input  logic                  rd_i,
    output logic                  ack_o,
    output logic [15:0]           state_value
);

    localparam int unsigned MEM_ADDR_W = LINE_ADDR_W + BEAT_W;

    if (LINE_ADDR_W + LINE_OFFSET_BITS >= REQ_ADDR_W) begin : g_bad_line_addr_w
        $error("LINE_ADDR_W too large for the 29-bit line address");
    end
    if (DELAY_CYCLES > 65535) begin : g_bad_delay
        $error("DELAY_CYCLES out of range");
    end

    state_e                  state;
    logic [BEAT_W-1:0]       beat;
    logic                    op_write;
    logic [LINE_ADDR_W-1:0]  line_idx;
    logic [LINE_W-1:0]       line_q;
    logic                    cap_valid;
    logic [BEAT_W-1:0]       cap_lane;
    logic                    ram_we;
    logic [MEM_ADDR_W-1:0]   ram_addr;
    logic [WORD_W-1:0]       ram_wdata;
    logic [WORD_W-1:0]       ram_rdata;
    logic                    unused_addr_bits;

`ifdef LINE_RAM_DELAY_EN
    localparam int unsigned WAIT_W = (DELAY_CYCLES > 0) ? $clog2(DELAY_CYCLES + 1) : 1;
    logic [WAIT_W-1:0] wait_cnt;
`endif

    // Offset bits and bits above the line index do not take part in decoding,
    // so addresses alias onto the stored lines.
    assign unused_addr_bits = ^{addr_i[LINE_OFFSET_BITS-1:0],
                                addr_i[REQ_ADDR_W-1:LINE_ADDR_W+LINE_OFFSET_BITS]};

    assign ram_we    = (state == ST_XFER) && op_write;
    assign ram_addr  = {line_idx, beat};
    assign ram_wdata = line_word(line_q, beat);

    assign state_value = pack_state_value(state, {1'b0, beat}, op_write, state != ST_IDLE);

    line_ram_word_mem #(
        .ADDR_W (MEM_ADDR_W),
        .DATA_W (WORD_W)
    ) u_mem (
        .clk   (clk),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    // Request handshake: latch the request, walk the eight beats, pulse ack
    // once, then hold off until the initiator drops its request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            beat     <= '0;
            op_write <= 1'b0;
            line_idx <= '0;
            line_q   <= '0;
            ack_o    <= 1'b0;
`ifdef LINE_RAM_DELAY_EN
            wait_cnt <= '0;
`endif
        end else begin
            ack_o <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (we_i || rd_i) begin
                        line_idx <= addr_i[LINE_ADDR_W+LINE_OFFSET_BITS-1:LINE_OFFSET_BITS];
                        line_q   <= data_i;
                        op_write <= we_i;
                        beat     <= '0;
`ifdef LINE_RAM_DELAY_EN
                        if (DELAY_CYCLES != 0) begin
                            state    <= ST_WAIT;
                            wait_cnt <= WAIT_W'(DELAY_CYCLES - 1);
                        end else begin
                            state <= ST_XFER;
                        end
`else
                        state <= ST_XFER;
`endif
                    end
                end
`ifdef LINE_RAM_DELAY_EN
                ST_WAIT: begin
                    if (wait_cnt == '0) begin
                        state <= ST_XFER;
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end
`endif
                ST_XFER: begin
                    beat <= beat + 1'b1;
                    if (beat == BEAT_W'(BEATS_PER_LINE - 1)) begin
                        if (op_write) begin
                            state <= ST_ACK;
                            ack_o <= 1'b1;
                        end else begin
                            state <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    state <= ST_ACK;
                    ack_o <= 1'b1;
                end
                ST_ACK: begin
                    state <= ST_RELEASE;
                end
                ST_RELEASE: begin
                    if (!we_i && !rd_i) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Read capture: RAM data appears one cycle after the beat address, so the
    // lane number is delayed alongside a valid flag. Writes never touch data_o.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cap_valid <= 1'b0;
            cap_lane  <= '0;
            data_o    <= '0;
        end else begin
            cap_valid <= (state == ST_XFER) && !op_write;
            cap_lane  <= beat;
            if (cap_valid) begin
                data_o[cap_lane*WORD_W +: WORD_W] <= ram_rdata;
            end
        end
    end

endmodule

// File: tb/tb_line_ram_responder.sv
// Self-checking bench for line_ram_responder: directed handshake, alias,
// write-priority, held-request and reset-abort steps followed by random
// line traffic checked against an array model of the stored lines.
// Build with LINE_RAM_DELAY_EN defined to exercise the WAIT state.
module tb_line_ram_responder;

    localparam int LINE_ADDR_W = 10;
    localparam int DELAY       = 4;
`ifdef LINE_RAM_DELAY_EN
    localparam int EXTRA = DELAY;
`else
    localparam int EXTRA = 0;
`endif
    localparam int TIMEOUT = 40 + EXTRA;

    logic         clk = 1'b0;
    logic         rst;
    logic [28:0]  addr_i;
    logic [255:0] data_i;
    logic [255:0] data_o;
    logic         we_i;
    logic         rd_i;
    logic         ack_o;
    logic [15:0]  state_value;

    int checks   = 0;
    int failures = 0;

    logic [255:0] modelMem [0:(1<<LINE_ADDR_W)-1];
    int           writtenLines[$];
    logic [255:0] expData;

    line_ram_responder #(
        .LINE_ADDR_W  (LINE_ADDR_W),
        .DELAY_CYCLES (DELAY)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .addr_i      (addr_i),
        .data_i      (data_i),
        .data_o      (data_o),
        .we_i        (we_i),
        .rd_i        (rd_i),
        .ack_o       (ack_o),
        .state_value (state_value)
    );

    // 100 MHz clock
    always #5 clk = ~clk;

    // Global time limit in case the handshake deadlocks
    initial begin
        #500000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [255:0] observed, input logic [255:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    function automatic logic [255:0] randomLine();
        logic [255:0] v;
        for (int k = 0; k < 8; k++) v[k*32 +: 32] = $urandom;
        return v;
    endfunction

    // Presents a request at a falling edge, holds it until ack plus holdAfter
    // cycles, and watches ack until the responder is back in IDLE.
    task automatic applyStimulus(input string tag, input logic w, input logic r,
                                 input logic [28:0] a, input logic [255:0] d, input int holdAfter,
                                 output int ackAt, output int ackCount, output logic [255:0] ackData);
        int n;
        int endAt;
        logic [3:0] firstCode;
        n        = 0;
        endAt    = TIMEOUT;
        ackAt    = -1;
        ackCount = 0;
        ackData  = '0;
        firstCode = (EXTRA > 0) ? 4'd5 : 4'd1;
        we_i   = w;
        rd_i   = r;
        addr_i = a;
        data_i = d;
        while (n < endAt) begin
            @(negedge clk);
            n++;
            if (n == 1)
                checkOutput({tag, "_sv_first"}, 256'(state_value), 256'({firstCode, 4'd0, w, 6'b0, 1'b1}));
            if (n == EXTRA + 4)
                checkOutput({tag, "_sv_beat3"}, 256'(state_value), 256'({4'd1, 4'd3, w, 6'b0, 1'b1}));
            if (ack_o === 1'b1) begin
                ackCount++;
                if (ackAt < 0) begin
                    ackAt   = n;
                    ackData = data_o;
                    endAt   = n + holdAfter + 2;
                end
            end
            if (ackAt >= 0 && n == ackAt + holdAfter) begin
                we_i = 1'b0;
                rd_i = 1'b0;
            end
        end
        we_i = 1'b0;
        rd_i = 1'b0;
        checkOutput({tag, "_idle"}, 256'({state_value[15:12], state_value[0]}), 256'(5'b0));
    endtask

    // Runs one transaction and compares timing, ack count and read data with the model.
    task automatic runAndCheck(input string tag, input logic w, input logic r,
                               input logic [28:0] a, input logic [255:0] d, input int hold);
        int ackAt;
        int ackCount;
        logic [255:0] ackData;
        int line;
        int expAck;
        line = int'(a[LINE_ADDR_W+4:5]);
        if (w) begin
            modelMem[line] = d;
            writtenLines.push_back(line);
            expAck = 9 + EXTRA;
        end else begin
            expData = modelMem[line];
            expAck  = 10 + EXTRA;
        end
        applyStimulus(tag, w, r, a, d, hold, ackAt, ackCount, ackData);
        checkOutput({tag, "_ack_time"}, 256'(ackAt), 256'(expAck));
        checkOutput({tag, "_ack_count"}, 256'(ackCount), 256'(1));
        checkOutput({tag, "_data"}, ackData, expData);
    endtask

    initial begin
        logic [255:0] line40;
        logic [255:0] newLine;
        logic [28:0]  a;
        int           line;
        logic         doWrite;
        logic         both;

        rst     = 1'b1;
        we_i    = 1'b0;
        rd_i    = 1'b0;
        addr_i  = '0;
        data_i  = '0;
        expData = '0;
        repeat (3) @(negedge clk);
        checkOutput("reset_ack", 256'(ack_o), 256'(0));
        checkOutput("reset_data", data_o, 256'(0));
        checkOutput("reset_sv", 256'(state_value), 256'(0));
        rst = 1'b0;
        @(negedge clk);

        for (int k = 0; k < 8; k++) line40[k*32 +: 32] = 32'(k + 1) * 32'h11111111;
        runAndCheck("wr_0x40", 1'b1, 1'b0, 29'h40, line40, 0);
        runAndCheck("rd_0x40", 1'b0, 1'b1, 29'h40, '0, 0);
        runAndCheck("rd_alias", 1'b0, 1'b1, 29'h40 + (29'd1 << (LINE_ADDR_W + 5)), '0, 0);
        runAndCheck("rd_offset", 1'b0, 1'b1, 29'h5F, '0, 0);
        runAndCheck("wr_both", 1'b1, 1'b1, 29'h40, {8{32'hDEADBEEF}}, 0);
        runAndCheck("rd_held", 1'b0, 1'b1, 29'h40, '0, 5);
        runAndCheck("wr_line3", 1'b1, 1'b0, 29'h60, randomLine(), 0);

        // Reset during beat 3 of a write to line 3
        newLine = randomLine();
        we_i    = 1'b1;
        rd_i    = 1'b0;
        addr_i  = 29'h60;
        data_i  = newLine;
        repeat (4 + EXTRA) @(posedge clk);
        #1;
        rst  = 1'b1;
        we_i = 1'b0;
        @(negedge clk);
        checkOutput("abort_ack", 256'(ack_o), 256'(0));
        checkOutput("abort_data", data_o, 256'(0));
        checkOutput("abort_sv", 256'(state_value), 256'(0));
        for (int k = 0; k < 3; k++) modelMem[3][k*32 +: 32] = newLine[k*32 +: 32];
        expData = '0;
        rst = 1'b0;
        runAndCheck("rd_after_abort", 1'b0, 1'b1, 29'h60, '0, 0);

        // Random traffic; reads only target lines with known contents
        for (int i = 0; i < 40; i++) begin
            doWrite = (writtenLines.size() == 0) || ($urandom_range(0, 1) == 1);
            if (doWrite) line = $urandom_range(0, (1 << LINE_ADDR_W) - 1);
            else         line = writtenLines[$urandom_range(0, writtenLines.size() - 1)];
            a = 29'($urandom);
            a[LINE_ADDR_W+4:5] = line[LINE_ADDR_W-1:0];
            both = doWrite && ($urandom_range(0, 3) == 0);
            runAndCheck($sformatf("rnd%0d", i), doWrite, !doWrite || both, a, randomLine(),
                        $urandom_range(0, 3));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule

// File: doc/line_ram_responder.md
Name: line_ram_responder

Overview:
- Responder end of the 256-bit line interface that the DDR3 cache controller drives: 29-bit address, 256-bit data, rd/we request, ack.
- Backs each line with on-chip block RAM, organised as 32-bit words with 8 beats per line.
- Replaces the DDR3 controller for DDR-less builds and for fast cache-controller simulation. Same handshake, no PHY.

Parameters:
- LINE_ADDR_W, 10, log2 of the number of lines stored (1024 lines = 32 KiB).
- DELAY_CYCLES, 16, extra wait cycles before the beat phase. Used only when LINE_RAM_DELAY_EN is defined.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- addr_i  in  29  line byte address. Bits [4:0] ignored. Bits [LINE_ADDR_W+4:5] select the line. Higher bits ignored, so addresses alias/wrap.
- data_i  in  256  write line. Word k = data_i[32k+31:32k].
- data_o  out  256  read line, same lane order.
- we_i  in  1  write request, level, held by initiator until ack_o.
- rd_i  in  1  read request, level, held by initiator until ack_o.
- ack_o  out  1  one-cycle completion pulse.
- state_value  out  16  debug: {state[3:0], beat[3:0], op_is_write, 6'b0, busy}.

Behaviour:
- Reset values: ack_o=0, data_o=0, state=IDLE, beat=0, state_value=0. RAM contents are not cleared.
- Reset asserted mid-transfer aborts to IDLE immediately. A partially written line keeps the beats already written. No ack is issued for the aborted request.
- States: IDLE, XFER, DRAIN, ACK, RELEASE. With LINE_RAM_DELAY_EN there is also a WAIT state.
- IDLE:
  - Samples the request in cycle T when (we_i | rd_i).
  - Latches line index, data_i (full 256 bits) and op.
  - If we_i and rd_i are both high, the write wins; the read is not performed.
  - Sets beat=0 and goes to XFER.
- XFER (cycles T+1..T+8), beat k=0..7:
  - Write: RAM word {line,k} = latched word k.
  - Read: issues RAM address {line,k}. The RAM has 1-cycle registered read latency.
  - beat increments and wraps 7→0. Leaving beat 7, a write goes to ACK and a read goes to DRAIN.
- Read capture: RAM output for beat k is written into data_o lane k in the cycle after its issue (T+2..T+9). DRAIN (T+9) captures lane 7.
- ACK:
  - ack_o=1 for exactly one cycle: T+9 for a write, T+10 for a read.
  - data_o holds the full line from the ack cycle until the next read's first capture. Writes never modify data_o.
- RELEASE: waits until we_i=0 and rd_i=0, then returns to IDLE. This prevents a held request being serviced twice. Minimum gap between two ack pulses is 11 cycles.
- Requests that change during XFER/DRAIN/ACK are ignored. The latched copy is used.
- busy=1 in every state except IDLE.
- Read-after-write to the same line returns the new data, because the write has completed before ack.

Optional Feature:
- Macro LINE_RAM_DELAY_EN.
- Defined: IDLE goes to WAIT, which counts DELAY_CYCLES cycles (counter width clog2(DELAY_CYCLES+1)) before XFER. All ack times shift by DELAY_CYCLES. DELAY_CYCLES=0 behaves as undefined.
- Undefined: the WAIT state and counter do not exist; timing is exactly as above.

Decomposition:
- Shared package holds:
  - state encoding constants (IDLE=0, XFER=1, DRAIN=2, ACK=3, RELEASE=4, WAIT=5);
  - BEATS_PER_LINE=8, WORD_W=32, LINE_W=256, LINE_OFFSET_BITS=5;
  - the state_value field layout, shared with the DDR3 controller debug display.
- One sub-module: line_ram_word_mem. Single-port 32-bit synchronous RAM with 2^(LINE_ADDR_W+3) words, registered read, write-first disabled (read-old). Kept separate so it can be replaced by a vendor BRAM primitive.

Test Plan:
- Write line addr 0x0000040, data_i words 0x11111111..0x88888888, we_i held → ack_o pulses exactly at T+9. Then read 0x0000040 → ack at T+10, data_o equals the written line.
- Read addr 0x0000040 and alias 0x0000040 + (1<<(LINE_ADDR_W+5)) → identical data_o (wrap). Low offset 0x5F vs 0x40 → same line.
- we_i=rd_i=1 with data 0xDEADBEEF in every word → write performed, ack at T+9, data_o unchanged from the previous read.
- Initiator holds rd_i 5 cycles past ack → exactly one ack. A new request issued in the cycle after release completes normally.
- Assert rst at T+4 of a write to line 3 → ack_o and data_o are 0 next edge. Read of line 3 afterwards shows beats 0-2 new and 3-7 old.
- With LINE_RAM_DELAY_EN and DELAY_CYCLES=4 → write ack at T+13, read ack at T+14. state_value[15:12]=5 during the wait.
